// File: rtl/psram_async_arbiter_if.sv
// rtl/psram_async_arbiter_if.sv - requester, response and PSRAM pin bundle for the async arbiter
interface psram_async_arbiter_if #(
    parameter int ADDR_W = 23
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [15:0]       req0_wdata;
    logic [1:0]        req0_be;
    logic              req0_ready;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [15:0]       req1_wdata;
    logic [1:0]        req1_be;
    logic              req1_ready;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [15:0]       rsp_rdata;

    logic [ADDR_W-1:0] psram_addr;
    logic              psram_ce_n;
    logic              psram_oen;
    logic              psram_wen;
    logic [1:0]        psram_ben;
    logic              psram_adv_ldn;
    logic              psram_cre;
    logic [15:0]       psram_dq_o;
    logic              psram_dq_t;
    logic [15:0]       psram_dq_i;

    // Requesters plus the pad side (which supplies psram_dq_i).
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        output psram_dq_i,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        input  psram_addr, psram_ce_n, psram_oen, psram_wen, psram_ben,
        input  psram_adv_ldn, psram_cre, psram_dq_o, psram_dq_t
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        input  psram_dq_i,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        output psram_addr, psram_ce_n, psram_oen, psram_wen, psram_ben,
        output psram_adv_ldn, psram_cre, psram_dq_o, psram_dq_t
    );
endinterface

// File: rtl/psram_async_arbiter.sv
// rtl/psram_async_arbiter.sv - two-port round-robin async PSRAM controller with programmable cycle counts
module psram_async_arbiter #(
    parameter int ADDR_W = 23,
    parameter int T_ACC  = 7,
    parameter int T_WP   = 6,
    parameter int T_TURN = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    psram_async_arbiter_if.slave   bus
);
    localparam int T_MAX_AW = (T_ACC > T_WP) ? T_ACC : T_WP;
    localparam int T_MAX    = (T_MAX_AW > T_TURN) ? T_MAX_AW : T_TURN;
    localparam int CNT_W    = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] ACC_LD  = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] WP_LD   = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(T_TURN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACC   = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        TURN     = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant;
    logic              r_port;

    logic [ADDR_W-1:0] r_addr;
    logic              r_ce_n;
    logic              r_oen;
    logic              r_wen;
    logic [1:0]        r_ben;
    logic [15:0]       r_dq_o;
    logic              r_dq_t;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [15:0]       r_rdata;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [15:0]       w_sel_wdata;
    logic [1:0]        w_sel_be;

    // Accept is decided in the IDLE cycle itself so a withdrawn request is never granted;
    // ties go to the port that did not win last time.
    assign w_idle   = (r_state == IDLE) && !sys_rst;
    assign w_grant0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    assign w_sel_we    = w_grant1 ? bus.req1_we    : bus.req0_we;
    assign w_sel_addr  = w_grant1 ? bus.req1_addr  : bus.req0_addr;
    assign w_sel_wdata = w_grant1 ? bus.req1_wdata : bus.req0_wdata;
    assign w_sel_be    = w_grant1 ? bus.req1_be    : bus.req0_be;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= '0;
            r_ce_n       <= 1'b1;
            r_oen        <= 1'b1;
            r_wen        <= 1'b1;
            r_ben        <= 2'b11;
            r_dq_o       <= 16'h0000;
            r_dq_t       <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rdata      <= 16'h0000;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_port       <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_addr       <= w_sel_addr;
                        r_ce_n       <= 1'b0;
                        if (w_sel_we) begin
                            r_state <= WR_PULSE;
                            r_cnt   <= WP_LD;
                            r_wen   <= 1'b0;
                            r_ben   <= ~w_sel_be;
                            r_dq_o  <= w_sel_wdata;
                            r_dq_t  <= 1'b0;
                        end else begin
                            r_state <= RD_ACC;
                            r_cnt   <= ACC_LD;
                            r_oen   <= 1'b0;
                            r_ben   <= 2'b00;
                            r_dq_t  <= 1'b1;
                        end
                    end
                end
                RD_ACC: begin
                    if (r_cnt == '0) begin
                        r_rdata      <= bus.psram_dq_i;
                        r_state      <= TURN;
                        r_cnt        <= TURN_LD;
                        r_ce_n       <= 1'b1;
                        r_oen        <= 1'b1;
                        r_ben        <= 2'b11;
                        r_rsp0_valid <= !r_port;
                        r_rsp1_valid <= r_port;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= WR_HOLD;
                        r_wen   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    // WE# already high; address and data were held one extra cycle.
                    r_state <= TURN;
                    r_cnt   <= TURN_LD;
                    r_ce_n  <= 1'b1;
                    r_ben   <= 2'b11;
                    r_dq_t  <= 1'b1;
                end
                TURN: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ce_n  <= 1'b1;
                    r_oen   <= 1'b1;
                    r_wen   <= 1'b1;
                    r_ben   <= 2'b11;
                    r_dq_t  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req0_ready    = w_grant0;
    assign bus.req1_ready    = w_grant1;
    assign bus.rsp0_valid    = r_rsp0_valid;
    assign bus.rsp1_valid    = r_rsp1_valid;
    assign bus.rsp_rdata     = r_rdata;
    assign bus.psram_addr    = r_addr;
    assign bus.psram_ce_n    = r_ce_n;
    assign bus.psram_oen     = r_oen;
    assign bus.psram_wen     = r_wen;
    assign bus.psram_ben     = r_ben;
    assign bus.psram_adv_ldn = 1'b0;
    assign bus.psram_cre     = 1'b0;
    assign bus.psram_dq_o    = r_dq_o;
    assign bus.psram_dq_t    = r_dq_t;
endmodule

// File: tb/tb_psram_async_arbiter.sv
// tb/tb_psram_async_arbiter.sv - directed self-checking bench for psram_async_arbiter
module tb_psram_async_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    psram_async_arbiter_if #(.ADDR_W(23)) bus ();

    psram_async_arbiter #(.ADDR_W(23), .T_ACC(7), .T_WP(6), .T_TURN(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [5:0] pins();
        return {bus.psram_ce_n, bus.psram_oen, bus.psram_wen, bus.psram_dq_t, bus.psram_ben};
    endfunction

    int g_port [8];
    int g_cyc  [8];
    int n_g;
    int viol, first_hi, read_lo, rd_rdy, cnt_rdy0, cnt_ce, cnt_rsp0, cnt_rsp1;

    initial begin
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_be = '0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_be = '0;
        bus.psram_dq_i = 16'h1111;
        repeat (3) step();

        // Reset state
        chk("rst_pins", pins(), 6'b111111);
        chk("rst_addr", bus.psram_addr, 0);
        chk("rst_dq_o", bus.psram_dq_o, 0);
        chk("rst_adv_cre", {bus.psram_adv_ldn, bus.psram_cre}, 0);
        chk("rst_ready_rsp", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        sys_rst = 0;
        step();

        // Test 1: port0 read
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 23'h000123;
        #1;
        chk("t1_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        chk("t1_c0_ce", bus.psram_ce_n, 1);
        step();
        bus.req0_valid = 0;
        for (int k = 1; k <= 7; k++) begin
            chk("t1_rd_pins", pins(), 6'b001100);
            chk("t1_rd_addr", bus.psram_addr, 23'h000123);
            chk("t1_rd_ready", bus.req0_ready, 0);
            if (k == 7) bus.psram_dq_i = 16'hBEEF;
            step();
        end
        bus.psram_dq_i = 16'h0000;
        chk("t1_c8_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b10);
        chk("t1_c8_rdata", bus.rsp_rdata, 16'hBEEF);
        chk("t1_c8_pins", pins(), 6'b111111);
        step();
        chk("t1_c9_rsp", bus.rsp0_valid, 0);
        step();

        // Test 2: port1 write, then spacing to next accept
        bus.req1_valid = 1; bus.req1_we = 1; bus.req1_addr = 23'h7FFFFF;
        bus.req1_wdata = 16'hA55A; bus.req1_be = 2'b10;
        #1;
        chk("t2_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
        step();
        bus.req1_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            chk("t2_wp_pins", pins(), 6'b010001);
            chk("t2_wp_dq_o", bus.psram_dq_o, 16'hA55A);
            chk("t2_wp_addr", bus.psram_addr, 23'h7FFFFF);
            step();
        end
        chk("t2_hold", {bus.psram_ce_n, bus.psram_oen, bus.psram_wen, bus.psram_dq_t}, 4'b0110);
        step();
        chk("t2_c8_pins", pins(), 6'b111111);
        step();
        chk("t2_c9_pins", pins(), 6'b111111);
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 23'h000055;
        bus.psram_dq_i = 16'h1234;
        #1;
        chk("t2_c9_noready", bus.req1_ready, 0);
        step();
        chk("t2_c10_ready", bus.req1_ready, 1);
        step();
        bus.req1_valid = 0;
        repeat (7) step();
        chk("t2_rd_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b01);
        chk("t2_rd_rdata", bus.rsp_rdata, 16'h1234);
        repeat (2) step();

        // Test 3: both ports reading continuously
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 23'h1;
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 23'h2;
        #1;
        n_g = 0;
        for (int c = 0; c < 40; c++) begin
            if ((bus.req0_ready || bus.req1_ready) && n_g < 8) begin
                g_port[n_g] = bus.req1_ready ? 1 : 0;
                g_cyc[n_g]  = c;
                n_g++;
            end
            step();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("t3_ngrants", n_g, 4);
        chk("t3_order", {g_port[0][0], g_port[1][0], g_port[2][0], g_port[3][0]}, 4'b0101);
        chk("t3_cycles", {g_cyc[0][7:0], g_cyc[1][7:0], g_cyc[2][7:0], g_cyc[3][7:0]}, {8'd0, 8'd10, 8'd20, 8'd30});
        step();

        // Test 4: reset mid-read
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 23'h9;
        #1;
        chk("t4_ready", bus.req0_ready, 1);
        step();
        bus.req0_valid = 0;
        step();
        step();
        sys_rst = 1;
        step();
        chk("t4_pins", pins(), 6'b111111);
        chk("t4_addr", bus.psram_addr, 0);
        chk("t4_dq_o", bus.psram_dq_o, 0);
        chk("t4_rdata", bus.rsp_rdata, 0);
        sys_rst = 0;
        cnt_rsp0 = 0; cnt_ce = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp0_valid) cnt_rsp0++;
            if (!bus.psram_ce_n) cnt_ce++;
            step();
        end
        chk("t4_no_rsp", cnt_rsp0, 0);
        chk("t4_no_access", cnt_ce, 0);
        bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_we = 0; bus.req1_we = 0;
        #1;
        chk("t4_post_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (10) step();

        // Test 5: write then immediate read on port0
        bus.req0_valid = 1; bus.req0_we = 1; bus.req0_addr = 23'h40;
        bus.req0_wdata = 16'h1357; bus.req0_be = 2'b11;
        #1;
        chk("t5_wr_ready", bus.req0_ready, 1);
        step();
        bus.req0_we = 0;
        viol = 0; first_hi = -1; read_lo = -1; rd_rdy = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!bus.psram_oen && (!bus.psram_wen || !bus.psram_dq_t)) viol++;
            if (first_hi < 0 && bus.psram_ce_n) first_hi = k;
            if (first_hi >= 0 && read_lo < 0 && !bus.psram_ce_n) read_lo = k;
            if (bus.req0_ready && rd_rdy < 0) rd_rdy = k;
            if (k == 18) chk("t5_rsp", bus.rsp0_valid, 1);
            step();
            if (rd_rdy >= 0) bus.req0_valid = 0;
        end
        chk("t5_viol", viol, 0);
        chk("t5_rd_ready_cyc", rd_rdy, 10);
        chk("t5_first_hi", first_hi, 8);
        chk("t5_gap", read_lo - first_hi, 3);

        // Test 6: port0 withdraws while port1 is accepted
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 23'h77;
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 23'h88;
        #1;
        chk("t6_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
        bus.req0_valid = 0;
        #1;
        chk("t6_ready_after_drop", {bus.req0_ready, bus.req1_ready}, 2'b01);
        step();
        bus.req1_valid = 0;
        cnt_rdy0 = 0; cnt_ce = 0; cnt_rsp0 = 0; cnt_rsp1 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.req0_ready) cnt_rdy0++;
            if (!bus.psram_ce_n) cnt_ce++;
            if (bus.rsp0_valid) cnt_rsp0++;
            if (bus.rsp1_valid) cnt_rsp1++;
            step();
        end
        chk("t6_no_ready0", cnt_rdy0, 0);
        chk("t6_ce_cycles", cnt_ce, 7);
        chk("t6_rsp0", cnt_rsp0, 0);
        chk("t6_rsp1", cnt_rsp1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
